// File: rtl/wash_pkg.sv
// wash_pkg: phase encodings and default phase durations for the wash cycle scheduler
package wash_pkg;
  typedef enum logic [2:0] {
    PH_START = 3'd0,
    PH_WASH  = 3'd1,
    PH_SPIN  = 3'd2,
    PH_DRY   = 3'd3,
    PH_FIN   = 3'd4,
    PH_HALT  = 3'd5
  } phase_e;
  localparam int DEF_START = 3;
  localparam int DEF_WASH  = 10;
  localparam int DEF_SPIN  = 5;
  localparam int DEF_DRY   = 5;
  localparam int DEF_FIN   = 3;
  localparam int DEF_HALT  = 2;
endpackage

// File: rtl/wash_cycle_scheduler_rr_arbiter.sv
// rr_arbiter: combinational round-robin pick of the first set req bit at or above ptr
module rr_arbiter #(
  parameter int N_REQ = 4,
  parameter int PW = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
  input  logic [N_REQ-1:0] req,
  input  logic [PW-1:0]    ptr,
  output logic [N_REQ-1:0] gnt
);
  logic          found;
  logic [PW-1:0] idx;
  always_comb begin
    gnt = '0;
    found = 1'b0;
    idx = '0;
    for (int i = 0; i < N_REQ; i++) begin
      idx = PW'((int'(ptr) + i) % N_REQ);
      if (!found && req[idx]) begin
        gnt[idx] = 1'b1;
        found = 1'b1;
      end
    end
  end
endmodule

// File: rtl/wash_cycle_scheduler.sv
// wash_cycle_scheduler: round-robin owner of one wash machine, running timed phases with door pause and abort
module wash_cycle_scheduler
  import wash_pkg::*;
#(
  parameter int N_REQ   = 4,
  parameter int CW      = 8,
  parameter int D_START = DEF_START,
  parameter int D_WASH  = DEF_WASH,
  parameter int D_SPIN  = DEF_SPIN,
  parameter int D_DRY   = DEF_DRY,
  parameter int D_FIN   = DEF_FIN,
  parameter int D_HALT  = DEF_HALT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_REQ-1:0] req,
  input  logic [N_REQ-1:0] quick,
  input  logic             door_closed,
  input  logic             abort,
  output logic [N_REQ-1:0] grant,
  output logic             busy,
  output logic [2:0]       phase,
  output logic             paused,
  output logic [N_REQ-1:0] done,
  output logic             aborted
);
  localparam int PW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  logic [N_REQ-1:0] grant_q, grant_d, done_q, done_d, win;
  logic             busy_q, busy_d, prog_q, prog_d, paused_q, paused_d, aborted_q, aborted_d;
  phase_e           phase_q, phase_d;
  logic [CW-1:0]    cnt_q, cnt_d, d_eff;
  logic [PW-1:0]    ptr_q, ptr_d, ptr_nxt;
  logic             last, hold;
  rr_arbiter #(.N_REQ(N_REQ), .PW(PW)) u_arb (.req(req), .ptr(ptr_q), .gnt(win));
  always_comb begin
    ptr_nxt = '0;
    for (int i = 0; i < N_REQ; i++) if (win[i]) ptr_nxt = PW'((i + 1) % N_REQ);
    d_eff = phase_q == PH_START ? CW'(D_START)
          : phase_q == PH_WASH  ? CW'(prog_q ? D_WASH >> 1 : D_WASH)
          : phase_q == PH_SPIN  ? CW'(D_SPIN)
          : phase_q == PH_DRY   ? CW'(prog_q ? D_DRY >> 1 : D_DRY)
          : phase_q == PH_FIN   ? CW'(D_FIN) : CW'(D_HALT);
    last = cnt_q == d_eff - CW'(1);
    // the door only interlocks the four timed phases, never FINISHED or HALT
    hold = busy_q && phase_q != PH_FIN && phase_q != PH_HALT && !door_closed;
    grant_d = grant_q;
    busy_d = busy_q;
    phase_d = phase_q;
    cnt_d = cnt_q;
    prog_d = prog_q;
    ptr_d = ptr_q;
    paused_d = 1'b0;
    done_d = '0;
    aborted_d = 1'b0;
    if (!busy_q) begin
      if (|req) begin
        grant_d = win;
        busy_d = 1'b1;
        phase_d = PH_START;
        cnt_d = '0;
        prog_d = |(quick & win);
        ptr_d = ptr_nxt;
      end
    end else if (abort && phase_q != PH_HALT) begin
      phase_d = PH_HALT;
      cnt_d = '0;
      aborted_d = 1'b1;
    end else if (hold) begin
      paused_d = 1'b1;
    end else if (last) begin
      cnt_d = '0;
      phase_d = phase_q == PH_HALT ? PH_START : phase_e'(phase_q + 3'd1);
      done_d = phase_q == PH_FIN ? grant_q : '0;
      busy_d = phase_q != PH_HALT;
      grant_d = phase_q == PH_HALT ? '0 : grant_q;
    end else begin
      cnt_d = cnt_q + CW'(1);
    end
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      grant_q <= '0;
      busy_q <= 1'b0;
      phase_q <= PH_START;
      cnt_q <= '0;
      prog_q <= 1'b0;
      ptr_q <= '0;
      paused_q <= 1'b0;
      done_q <= '0;
      aborted_q <= 1'b0;
    end else begin
      grant_q <= grant_d;
      busy_q <= busy_d;
      phase_q <= phase_d;
      cnt_q <= cnt_d;
      prog_q <= prog_d;
      ptr_q <= ptr_d;
      paused_q <= paused_d;
      done_q <= done_d;
      aborted_q <= aborted_d;
    end
  end
  assign grant = grant_q;
  assign busy = busy_q;
  assign phase = phase_q;
  assign paused = paused_q;
  assign done = done_q;
  assign aborted = aborted_q;
endmodule

// File: tb/tb_wash_cycle_scheduler.sv
// tb_wash_cycle_scheduler: randomized cycles scored per transaction against a phase-duration model
module tb_wash_cycle_scheduler;
  logic clk = 1'b0, rst = 1'b1;
  logic [3:0] req = '0, quick = '0;
  logic door_closed = 1'b1, abort = 1'b0;
  logic [3:0] grant, done;
  logic busy, paused, aborted;
  logic [2:0] phase;
  always #5 clk = ~clk;
  wash_cycle_scheduler dut (.clk(clk), .rst(rst), .req(req), .quick(quick), .door_closed(door_closed),
    .abort(abort), .grant(grant), .busy(busy), .phase(phase), .paused(paused), .done(done), .aborted(aborted));
  typedef struct {
    logic [3:0] grant; int gap; logic [23:0] ord; logic [47:0] lens; int paused; logic [3:0] done; logic ab;
  } exp_t;
  typedef struct { int mode; int s; int len; int a; } plan_t;
  exp_t expq[$];
  plan_t pq[$];
  int n_chk = 0, n_pass = 0, ptr_m = 0;
  bit first = 1'b1, mon_en = 1'b0;
  localparam int NT = 40;
  task automatic check(input string name, input logic [63:0] act, input logic [63:0] expv);
    n_chk++;
    if (act === expv) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, expv);
  endtask
  task automatic timeout(input string name);
    n_chk++;
    $display("FAIL %s: timed out waiting for the DUT", name);
  endtask
  function automatic int phase_at(input int d[6], input int c);
    int acc = 0;
    for (int p = 0; p < 6; p++) begin
      if (c < acc + d[p]) return p;
      acc += d[p];
    end
    return 6;
  endfunction
  // model: round-robin winner, then phase durations adjusted for program, pause window and abort point
  task automatic plan_push(input logic [3:0] r, input logic [3:0] q);
    int w = 0, tot = 0, ph, acc;
    bit found = 0, prog;
    int d[6];
    plan_t p;
    exp_t e;
    for (int i = 0; i < 4; i++) if (!found && r[(ptr_m + i) % 4]) begin w = (ptr_m + i) % 4; found = 1; end
    ptr_m = (w + 1) % 4;
    prog = q[w];
    d = '{3, prog ? 5 : 10, 5, prog ? 2 : 5, 3, 2};
    foreach (d[j]) tot += d[j];
    p.mode = $urandom_range(0, 2); p.s = 0; p.len = 0; p.a = 0;
    e.grant = 4'(1 << w); e.gap = first ? -1 : 1; first = 0; e.paused = 0; e.ab = 0;
    if (p.mode == 1) begin
      p.s = $urandom_range(0, tot - 1); p.len = $urandom_range(1, 8);
      ph = phase_at(d, p.s);
      if (ph < 4) begin d[ph] += p.len; e.paused = p.len; end
    end else if (p.mode == 2) begin
      p.a = ($urandom_range(0, 3) == 0) ? tot - 1 - int'($urandom_range(0, 1)) : int'($urandom_range(0, tot - 1));
      ph = phase_at(d, p.a);
      if (ph < 5) begin
        acc = 0;
        for (int j = 0; j < ph; j++) acc += d[j];
        d[ph] = p.a - acc + 1;
        for (int j = ph + 1; j < 5; j++) d[j] = 0;
        e.ab = 1;
      end
    end
    e.done = e.ab ? 4'b0 : e.grant;
    e.ord = '0; e.lens = '0;
    for (int j = 0; j < 6; j++) if (d[j] > 0) begin e.ord = {e.ord[20:0], 3'(j)}; e.lens[j*8 +: 8] = 8'(d[j]); end
    expq.push_back(e);
    pq.push_back(p);
  endtask
  bit pb = 0, gchg, aoth, afirst, ibad;
  int idle = 0, gap, npaus;
  int mlen[8];
  logic [3:0] g0, dfirst, doth;
  logic [23:0] ord;
  logic [47:0] pl;
  logic [2:0] lastph;
  exp_t e;
  always @(negedge clk) if (mon_en) begin
    if (busy) begin
      if (!pb) begin
        g0 = grant; gap = idle; ord = '0; lastph = 3'd7; npaus = 0; gchg = 0;
        dfirst = '0; doth = '0; afirst = 0; aoth = 0;
        foreach (mlen[j]) mlen[j] = 0;
      end
      if (phase != lastph) begin
        ord = {ord[20:0], phase};
        lastph = phase;
        if (phase == 3'd5) begin dfirst = done; afirst = aborted; end
        else begin doth |= done; aoth |= aborted; end
      end else begin
        doth |= done; aoth |= aborted;
      end
      mlen[phase]++;
      if (grant != g0) gchg = 1;
      if (paused) npaus++;
    end else begin
      if (pb) begin
        idle = 0;
        ibad = grant != 0 || phase != 0 || paused || done != 0 || aborted;
        pl = '0;
        for (int j = 0; j < 6; j++) pl[j*8 +: 8] = 8'(mlen[j]);
        if (expq.size() == 0) timeout("scoreboard_empty");
        else begin
          e = expq.pop_front();
          check("grant", g0, e.grant);
          if (e.gap >= 0) check("idle_gap", gap, e.gap);
          check("phase_order", ord, e.ord);
          check("phase_lengths", pl, e.lens);
          check("paused_cycles", npaus, e.paused);
          check("done", dfirst, e.done);
          check("aborted", afirst, e.ab);
          check("stray_pulses", {gchg, doth, aoth, ibad}, 0);
        end
      end
      idle++;
    end
    pb = busy;
  end
  initial begin
    logic [3:0] r, q;
    plan_t p;
    int t, k;
    repeat (3) @(negedge clk);
    check("reset_outputs", {grant, busy, phase, paused, done, aborted}, 0);
    rst = 1'b0;
    mon_en = 1'b1;
    r = 4'hF; q = '0;
    plan_push(r, q); req = r; quick = q;
    for (int n = 0; n < NT; n++) begin
      t = 0;
      while (!busy && t < 50) begin @(negedge clk); t++; end
      if (!busy) begin timeout("grant_wait"); break; end
      p = pq.pop_front();
      if (n < NT - 1) begin
        r = (n < 3) ? 4'hF : 4'($urandom_range(1, 15));
        q = (n < 3) ? 4'h0 : 4'($urandom);
        plan_push(r, q); req = r; quick = q;
      end else req = '0;
      k = 0;
      while (busy && k < 120) begin
        door_closed = !(p.mode == 1 && k >= p.s && k < p.s + p.len);
        abort = p.mode == 2 && k == p.a;
        @(negedge clk); k++;
      end
      if (busy) begin timeout("cycle_end_wait"); break; end
      door_closed = 1'($urandom_range(0, 1));
      abort = 1'($urandom_range(0, 1));
    end
    repeat (3) @(negedge clk);
    abort = 1'b0; door_closed = 1'b1;
    mon_en = 1'b0;
    check("scoreboard_drained", expq.size(), 0);
    req = 4'b0001; quick = '0;
    t = 0;
    while (!busy && t < 50) begin @(negedge clk); t++; end
    t = 0;
    while (phase != 3'd3 && t < 60) begin @(negedge clk); t++; end
    if (phase != 3'd3) timeout("drying_wait");
    #2 rst = 1'b1;
    #1 check("async_reset", {grant, busy, phase, paused, done, aborted}, 0);
    @(negedge clk);
    req = 4'hF;
    rst = 1'b0;
    @(negedge clk);
    check("grant_after_reset", grant, 4'b0001);
    check("busy_after_reset", busy, 1);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
